// File: rtl/if_pc_gen.sv
// rtl/if_pc_gen.sv - Fetch PC generator with in-flight branch stash and mispredict redirect
//
// Purpose:
//   Holds the fetch PC, presents it to the branch predictor as pc_jmp, and picks
//   the next PC from the predictor verdict.
//   Every predicted branch is pushed into a FIFO stash. Each entry records the
//   branch PC, the alternate (not-chosen) PC and the prediction.
//   When EX resolves the oldest branch, the block drives predictor feedback.
//   On a mispredict it also redirects fetch to the stored alternate PC.
//
// Optional feature:
//   IF_PC_GEN_PERF_EN - adds the perf_branches / perf_mispredicts counters.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   stall                 downstream hold: PC and stash push frozen
//   IF_is_branch          instruction at pc is a conditional branch
//   IF_branch_target      taken target of that branch
//   pc_prediction_take    predictor verdict for pc_jmp
//   EX_resolve, EX_taken  EX resolved the oldest branch, and its outcome
//   pc, pc_jmp            current fetch PC / predictor lookup PC
//   pc_jmp_feedback       predictor update strobe
//   pc_jmp_take           update outcome
//   pc_stash_base         PC of the branch being updated
//   flush                 mispredict, squash younger work
//   stash_full            stash holds STASH_DEPTH entries
//   perf_branches         (IF_PC_GEN_PERF_EN) resolved branch count
//   perf_mispredicts      (IF_PC_GEN_PERF_EN) mispredict count
module if_pc_gen #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          STASH_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        IF_is_branch,
    input  logic [31:0] IF_branch_target,
    input  logic        pc_prediction_take,
    input  logic        EX_resolve,
    input  logic        EX_taken,
    output logic [31:0] pc,
    output logic [31:0] pc_jmp,
    output logic        pc_jmp_feedback,
    output logic        pc_jmp_take,
    output logic [31:0] pc_stash_base,
    output logic        flush,
    output logic        stash_full
`ifdef IF_PC_GEN_PERF_EN
    ,
    output logic [31:0] perf_branches,
    output logic [31:0] perf_mispredicts
`endif
);

    localparam int PTR_W = (STASH_DEPTH > 1) ? $clog2(STASH_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      pc_q, pc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      bpc_q  [STASH_DEPTH];
    logic [31:0]      bpc_d  [STASH_DEPTH];
    logic [31:0]      alt_q  [STASH_DEPTH];
    logic [31:0]      alt_d  [STASH_DEPTH];
    logic             pred_q [STASH_DEPTH];
    logic             pred_d [STASH_DEPTH];

    logic        valid_pop;
    logic        mispredict;
    logic        do_push;
    logic        do_pop;
    logic [31:0] pc_plus4;
    logic [31:0] head_bpc;
    logic [31:0] head_alt;
    logic        head_pred;

    assign pc_plus4   = pc_q + 32'd4;
    assign head_bpc   = bpc_q[rd_ptr_q];
    assign head_alt   = alt_q[rd_ptr_q];
    assign head_pred  = pred_q[rd_ptr_q];
    // A resolve with an empty stash has no branch to attach to and is dropped.
    assign valid_pop  = EX_resolve && (count_q != '0);
    assign mispredict = valid_pop && (EX_taken != head_pred);
    assign stash_full = (count_q == CNT_W'(STASH_DEPTH));

    assign pc              = pc_q;
    assign pc_jmp          = pc_q;
    assign pc_jmp_feedback = valid_pop;
    assign pc_jmp_take     = valid_pop && EX_taken;
    assign pc_stash_base   = valid_pop ? head_bpc : 32'd0;
    assign flush           = mispredict;

    always_comb begin
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        bpc_d    = bpc_q;
        alt_d    = alt_q;
        pred_d   = pred_q;
        do_push  = 1'b0;
        do_pop   = 1'b0;

        if (mispredict) begin
            // Every younger entry was fetched down the wrong path, so drop them all.
            pc_d     = head_alt;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            do_pop = valid_pop;
            if (stall) begin
                pc_d = pc_q;
            end else if (IF_is_branch && stash_full && !valid_pop) begin
                // No room: hold fetch so the branch is re-presented next cycle.
                pc_d = pc_q;
            end else if (IF_is_branch) begin
                do_push = 1'b1;
                pc_d    = pc_prediction_take ? IF_branch_target : pc_plus4;
            end else begin
                pc_d = pc_plus4;
            end

            if (do_push) begin
                bpc_d[wr_ptr_q]  = pc_q;
                alt_d[wr_ptr_q]  = pc_prediction_take ? pc_plus4 : IF_branch_target;
                pred_d[wr_ptr_q] = pc_prediction_take;
                wr_ptr_d         = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < STASH_DEPTH; i++) begin
                bpc_q[i]  <= 32'd0;
                alt_q[i]  <= 32'd0;
                pred_q[i] <= 1'b0;
            end
        end else begin
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            bpc_q    <= bpc_d;
            alt_q    <= alt_d;
            pred_q   <= pred_d;
        end
    end

`ifdef IF_PC_GEN_PERF_EN
    logic [31:0] perf_branches_q, perf_branches_d;
    logic [31:0] perf_mispredicts_q, perf_mispredicts_d;

    always_comb begin
        perf_branches_d    = perf_branches_q + (valid_pop ? 32'd1 : 32'd0);
        perf_mispredicts_d = perf_mispredicts_q + (mispredict ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_branches_q    <= 32'd0;
            perf_mispredicts_q <= 32'd0;
        end else begin
            perf_branches_q    <= perf_branches_d;
            perf_mispredicts_q <= perf_mispredicts_d;
        end
    end

    assign perf_branches    = perf_branches_q;
    assign perf_mispredicts = perf_mispredicts_q;
`endif

endmodule
